// File: rtl/sram_clock_ctrl.sv
// Main/sub-SRAM read controller: fixed main window loaded from flash at reset, other addresses
// cached in SUB_NUM sub blocks filled from flash with clock (second-chance) replacement.
module sram_clock_ctrl #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       SUB_NUM     = 4,
  parameter int unsigned       LOG_SUB_NUM = 2,
  parameter int unsigned       SUB_DEPTH   = 256,
  parameter int unsigned       LOG_SUB_D   = 8,
  parameter logic [ADDR_W-1:0] MAIN_LOWER  = 'h0,
  parameter logic [ADDR_W-1:0] MAIN_UPPER  = 'h400,
  parameter int unsigned       MEM_AW      = 16
) (
  input  logic                   clk_i,
  input  logic                   grst_ni,
  input  logic                   re_i,
  input  logic [ADDR_W-1:0]      raddr_i,
  output logic                   rready_o,
  output logic                   rvalid_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   rmiss_o,
  output logic                   init_done_o,
  output logic                   fl_req_o,
  output logic [ADDR_W-1:0]      fl_addr_o,
  output logic [ADDR_W-1:0]      fl_len_o,
  input  logic                   fl_valid_i,
  input  logic [DATA_W-1:0]      fl_data_i,
  output logic                   mem_re_o,
  output logic                   mem_we_o,
  output logic [LOG_SUB_NUM:0]   mem_sel_o,
  output logic [MEM_AW-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  input  logic [DATA_W-1:0]      mem_rdata_i
);

  localparam int unsigned         TagW     = ADDR_W - LOG_SUB_D;
  localparam logic [ADDR_W-1:0]   MainSpan = MAIN_UPPER - MAIN_LOWER;
  localparam logic [MEM_AW:0]     MainLast = (MEM_AW+1)'(MainSpan - ADDR_W'(1));
  localparam logic [MEM_AW:0]     SubLast  = (MEM_AW+1)'(SUB_DEPTH - 1);
  localparam logic [MEM_AW:0]     CntOne   = (MEM_AW+1)'(1);
  localparam logic [LOG_SUB_NUM-1:0] PtrOne = LOG_SUB_NUM'(1);
  localparam logic [LOG_SUB_NUM:0]   SelOne = (LOG_SUB_NUM+1)'(1);

  typedef enum logic [2:0] {
    StInit, StIdle, StLookup, StRd, StResp, StVictim, StFill
  } state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [MEM_AW:0]                cnt_q, cnt_d;
  logic [SUB_NUM-1:0]             valid_q, valid_d;
  logic [SUB_NUM-1:0]             clock_q, clock_d;
  logic [SUB_NUM-1:0][TagW-1:0]   tag_q, tag_d;
  logic [LOG_SUB_NUM-1:0]         ptr_q, ptr_d;
  logic [LOG_SUB_NUM-1:0]         vic_q, vic_d;
  logic [DATA_W-1:0]              rdata_q, rdata_d;
  logic                           miss_q, miss_d;
  logic                           done_q, done_d;
  logic                           fl_req_q, fl_req_d;
  logic [ADDR_W-1:0]              fl_addr_q, fl_addr_d;
  logic [ADDR_W-1:0]              fl_len_q, fl_len_d;

  logic [ADDR_W-1:0]              main_off;
  logic                           main_hit;
  logic                           sub_hit;
  logic [LOG_SUB_NUM-1:0]         hit_idx;
  logic                           fl_word;

  // Unsigned wrap makes this a single exact [MAIN_LOWER, MAIN_UPPER) range test.
  assign main_off = addr_q - MAIN_LOWER;
  assign main_hit = main_off < MainSpan;
  assign fl_word  = fl_valid_i && fl_req_q;

  always_comb begin
    sub_hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < SUB_NUM; i++) begin
      if (valid_q[i] && tag_q[i] == addr_q[ADDR_W-1:LOG_SUB_D]) begin
        sub_hit = 1'b1;
        hit_idx = LOG_SUB_NUM'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    clock_d     = clock_q;
    tag_d       = tag_q;
    ptr_d       = ptr_q;
    vic_d       = vic_q;
    rdata_d     = rdata_q;
    miss_d      = miss_q;
    done_d      = done_q;
    fl_req_d    = fl_req_q;
    fl_addr_d   = fl_addr_q;
    fl_len_d    = fl_len_q;
    rready_o    = 1'b0;
    rvalid_o    = 1'b0;
    rmiss_o     = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_sel_o   = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      StInit: begin
        if (!fl_req_q) begin
          fl_req_d  = 1'b1;
          fl_addr_d = MAIN_LOWER;
          fl_len_d  = MainSpan;
          cnt_d     = '0;
        end else if (fl_word) begin
          mem_we_o    = 1'b1;
          mem_addr_o  = cnt_q[MEM_AW-1:0];
          mem_wdata_o = fl_data_i;
          cnt_d       = cnt_q + CntOne;
          if (cnt_q == MainLast) begin
            fl_req_d = 1'b0;
            done_d   = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StIdle: begin
        rready_o = 1'b1;
        if (re_i) begin
          addr_d  = raddr_i;
          miss_d  = 1'b0;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (main_hit) begin
          mem_re_o   = 1'b1;
          mem_addr_o = main_off[MEM_AW-1:0];
          state_d    = StRd;
        end else if (sub_hit) begin
          mem_re_o          = 1'b1;
          mem_sel_o         = {1'b0, hit_idx} + SelOne;
          mem_addr_o        = MEM_AW'(addr_q[LOG_SUB_D-1:0]);
          clock_d[hit_idx]  = 1'b1;
          state_d           = StRd;
        end else begin
          state_d = StVictim;
        end
      end
      StRd: begin
        rdata_d = mem_rdata_i;
        state_d = StResp;
      end
      StResp: begin
        rvalid_o = 1'b1;
        rmiss_o  = miss_q;
        state_d  = StIdle;
      end
      StVictim: begin
        if (!valid_q[ptr_q] || !clock_q[ptr_q]) begin
          vic_d          = ptr_q;
          valid_d[ptr_q] = 1'b0;
          fl_req_d       = 1'b1;
          fl_addr_d      = {addr_q[ADDR_W-1:LOG_SUB_D], {LOG_SUB_D{1'b0}}};
          fl_len_d       = ADDR_W'(SUB_DEPTH);
          cnt_d          = '0;
          miss_d         = 1'b1;
          state_d        = StFill;
        end else begin
          clock_d[ptr_q] = 1'b0;
          ptr_d          = ptr_q + PtrOne;
        end
      end
      StFill: begin
        if (fl_word) begin
          mem_we_o    = 1'b1;
          mem_sel_o   = {1'b0, vic_q} + SelOne;
          mem_addr_o  = cnt_q[MEM_AW-1:0];
          mem_wdata_o = fl_data_i;
          cnt_d       = cnt_q + CntOne;
          if (cnt_q == SubLast) begin
            fl_req_d       = 1'b0;
            tag_d[vic_q]   = addr_q[ADDR_W-1:LOG_SUB_D];
            valid_d[vic_q] = 1'b1;
            clock_d[vic_q] = 1'b1;
            ptr_d          = vic_q + PtrOne;
            state_d        = StLookup;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or negedge grst_ni) begin
    if (!grst_ni) begin
      state_q   <= StInit;
      addr_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= '0;
      clock_q   <= '0;
      tag_q     <= '0;
      ptr_q     <= '0;
      vic_q     <= '0;
      rdata_q   <= '0;
      miss_q    <= 1'b0;
      done_q    <= 1'b0;
      fl_req_q  <= 1'b0;
      fl_addr_q <= '0;
      fl_len_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      clock_q   <= clock_d;
      tag_q     <= tag_d;
      ptr_q     <= ptr_d;
      vic_q     <= vic_d;
      rdata_q   <= rdata_d;
      miss_q    <= miss_d;
      done_q    <= done_d;
      fl_req_q  <= fl_req_d;
      fl_addr_q <= fl_addr_d;
      fl_len_q  <= fl_len_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign init_done_o = done_q;
  assign fl_req_o    = fl_req_q;
  assign fl_addr_o   = fl_addr_q;
  assign fl_len_o    = fl_len_q;

endmodule

// File: tb/tb_sram_clock_ctrl.sv
// Bench for sram_clock_ctrl: flash and SRAM macro models, a transaction-level cache model
// checked every cycle, and directed reads with literal expectations.
module tb_sram_clock_ctrl;

  localparam logic [31:0] M_LO = 32'h0;
  localparam logic [31:0] M_HI = 32'h400;

  logic        clk, grst_n, re, rready, rvalid, rmiss, init_done, fl_req, fl_valid;
  logic        mem_re, mem_we;
  logic [31:0] raddr, rdata, fl_addr, fl_len, fl_data, mem_wdata, mem_rdata;
  logic [2:0]  mem_sel;
  logic [15:0] mem_addr;
  int          n_chk, n_fail;

  sram_clock_ctrl dut (
    .clk_i       (clk),
    .grst_ni     (grst_n),
    .re_i        (re),
    .raddr_i     (raddr),
    .rready_o    (rready),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .rmiss_o     (rmiss),
    .init_done_o (init_done),
    .fl_req_o    (fl_req),
    .fl_addr_o   (fl_addr),
    .fl_len_o    (fl_len),
    .fl_valid_i  (fl_valid),
    .fl_data_i   (fl_data),
    .mem_re_o    (mem_re),
    .mem_we_o    (mem_we),
    .mem_sel_o   (mem_sel),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction

  function automatic logic [31:0] flash_word(input logic [31:0] a);
    return ((a - M_LO) < (M_HI - M_LO)) ? (a - M_LO) : (a ^ 32'hC0DE_0000);
  endfunction

  // SRAM macros
  logic [31:0] main_mem [1024];
  logic [31:0] sub_mem  [4][256];
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_sel == 3'd0) main_mem[mem_addr[9:0]] <= mem_wdata;
      else sub_mem[mem_sel[1:0] - 2'd1][mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_re) begin
      mem_rdata <= (mem_sel == 3'd0) ? main_mem[mem_addr[9:0]]
                                     : sub_mem[mem_sel[1:0] - 2'd1][mem_addr[7:0]];
    end
  end

  // Flash: streams fl_len words from fl_addr while fl_req is high, optionally with gaps
  bit          gap_en, fl_active;
  int unsigned fl_idx, fl_total, gap_ph;
  logic [31:0] fl_base;
  always @(negedge clk) begin
    if (!fl_req) begin
      fl_active = 1'b0;
      fl_valid  = 1'b0;
    end else begin
      if (!fl_active) begin
        fl_active = 1'b1;
        fl_idx    = 0;
        fl_base   = fl_addr;
        fl_total  = fl_len;
      end
      gap_ph++;
      if (fl_idx < fl_total && !(gap_en && (gap_ph % 3) == 1)) begin
        fl_valid = 1'b1;
        fl_data  = flash_word(fl_base + fl_idx);
        fl_idx++;
      end else begin
        fl_valid = 1'b0;
      end
    end
  end

  // Transaction-level model: the cache decision for a request is made once, at accept
  bit          m_init, pend, p_hit, prev_req, rising;
  int          m_wcnt, m_hand, p_age, p_vic, p_nre, hit_i;
  bit          m_val [4];
  bit          m_ref [4];
  logic [23:0] m_tag [4];
  logic [31:0] p_addr;
  logic [2:0]  p_sel;
  logic [15:0] p_off;

  always @(negedge clk) begin
    #1;
    if (!grst_n) begin
      chk("rst_flags", {rready, rvalid, rmiss, init_done, fl_req, mem_re, mem_we}, 0);
      chk("rst_buses", rdata | fl_addr | fl_len | mem_wdata | 32'(mem_addr) | 32'(mem_sel), 0);
      m_init = 0; m_wcnt = 0; m_hand = 0; pend = 0; prev_req = 0;
      for (int i = 0; i < 4; i++) begin m_val[i] = 0; m_ref[i] = 0; m_tag[i] = '0; end
    end else begin
      rising = fl_req && !prev_req;
      chk("we_re_excl", 32'(mem_we & mem_re), 0);
      if (!m_init) begin
        chk("init_flags", {init_done, rready, rvalid, mem_re}, 0);
        if (rising) begin
          chk("init_fl_addr", fl_addr, M_LO);
          chk("init_fl_len", fl_len, M_HI - M_LO);
        end
        if (mem_we) begin
          chk("init_we_sel", 32'(mem_sel), 0);
          chk("init_we_addr", 32'(mem_addr), m_wcnt);
          chk("init_we_data", mem_wdata, flash_word(M_LO + m_wcnt));
          m_wcnt++;
          if (m_wcnt == int'(M_HI - M_LO)) m_init = 1;
        end
      end else begin
        chk("init_done_hold", 32'(init_done), 1);
        chk("rready", 32'(rready), 32'(!pend));
        if (pend) begin
          p_age++;
          if (rising) begin
            chk("fill_fl_hit", 32'(p_hit), 0);
            chk("fill_fl_addr", fl_addr, p_addr & 32'hFFFF_FF00);
            chk("fill_fl_len", fl_len, 256);
          end
          if (mem_we) begin
            chk("fill_we_hit", 32'(p_hit), 0);
            chk("fill_we_sel", 32'(mem_sel), p_vic + 1);
            chk("fill_we_addr", 32'(mem_addr), m_wcnt);
            chk("fill_we_data", mem_wdata, flash_word((p_addr & 32'hFFFF_FF00) + m_wcnt));
            m_wcnt++;
          end
          if (mem_re) begin
            p_nre++;
            chk("rd_sel", 32'(mem_sel), 32'(p_sel));
            chk("rd_addr", 32'(mem_addr), 32'(p_off));
          end
          if (rvalid) begin
            chk("resp_data", rdata, flash_word(p_addr));
            chk("resp_miss", 32'(rmiss), 32'(!p_hit));
            chk("resp_nre", p_nre, 1);
            chk("resp_fill_words", m_wcnt, p_hit ? 0 : 256);
            if (p_hit) chk("resp_hit_latency", p_age, 3);
            pend = 0;
          end else if (p_age > 3000) begin
            chk("resp_timeout", 0, 1);
            pend = 0;
          end
        end else begin
          chk("idle_quiet", {rvalid, mem_we, mem_re, rising}, 0);
        end
        if (re && rready) begin
          pend = 1; p_addr = raddr; p_age = 0; p_nre = 0; m_wcnt = 0; p_vic = 0;
          if ((raddr - M_LO) < (M_HI - M_LO)) begin
            p_hit = 1; p_sel = 3'd0; p_off = 16'(raddr - M_LO);
          end else begin
            hit_i = -1;
            for (int i = 0; i < 4; i++) if (m_val[i] && m_tag[i] == raddr[31:8]) hit_i = i;
            if (hit_i >= 0) begin
              p_hit = 1; m_ref[hit_i] = 1; p_sel = 3'(hit_i + 1);
            end else begin
              p_hit = 0;
              while (m_val[m_hand] && m_ref[m_hand]) begin
                m_ref[m_hand] = 0;
                m_hand = (m_hand + 1) % 4;
              end
              p_vic = m_hand;
              m_val[p_vic] = 1; m_ref[p_vic] = 1; m_tag[p_vic] = raddr[31:8];
              m_hand = (p_vic + 1) % 4;
              p_sel = 3'(p_vic + 1);
            end
            p_off = {8'h0, raddr[7:0]};
          end
        end
      end
      prev_req = fl_req;
    end
  end

  task automatic wait_init(output int nwe);
    int k;
    nwe = 0;
    for (k = 0; k < 3000; k++) begin
      #2;
      if (mem_we && mem_sel == 3'd0) nwe++;
      if (init_done) break;
      @(negedge clk);
    end
    if (k == 3000) chk("init_timeout", 0, 1);
  endtask

  task automatic reset_init();
    int nwe;
    @(negedge clk);
    grst_n = 1'b0; re = 1'b0; gap_en = 1'b0;
    repeat (2) @(negedge clk);
    grst_n = 1'b1;
    wait_init(nwe);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic m,
                         output int lat, output logic [2:0] sel, output logic [15:0] off,
                         output logic [2:0] wsel, output logic [31:0] fa, output logic [31:0] fln);
    int cyc;
    bit acc, done, seen_we, seen_fl;
    acc = 0; done = 0; seen_we = 0; seen_fl = 0;
    d = '0; m = 0; lat = 0; sel = '0; off = '0; wsel = '0; fa = '0; fln = '0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      re = 1'b1; raddr = a;
      #2 acc = rready;
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      re = 1'b0;
      return;
    end
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      re = 1'b0;
      cyc++;
      #2;
      if (mem_re) begin sel = mem_sel; off = mem_addr; end
      if (mem_we && !seen_we) begin wsel = mem_sel; seen_we = 1; end
      if (fl_req && !seen_fl) begin fa = fl_addr; fln = fl_len; seen_fl = 1; end
      if (rvalid) begin done = 1; d = rdata; m = rmiss; lat = cyc; end
    end
    if (!done) chk("read_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, fa, fln;
    logic        m;
    int          lat, nwe, cnt, n_acc, n_rv, k;
    logic [2:0]  sel, wsel;
    logic [15:0] off;
    logic [31:0] addrs [4];

    n_chk = 0; n_fail = 0;
    grst_n = 1'b0; re = 1'b0; raddr = '0; fl_valid = 1'b0; fl_data = '0; gap_en = 1'b0;

    // T1: reset state, main window load
    repeat (2) @(negedge clk);
    #2;
    chk("t1_rst_rready", 32'(rready), 0);
    chk("t1_rst_init_done", 32'(init_done), 0);
    @(negedge clk);
    grst_n = 1'b1;
    wait_init(nwe);
    chk("t1_main_writes", nwe, 1024);
    chk("t1_init_done", 32'(init_done), 1);
    chk("t1_rready", 32'(rready), 1);
    chk("t1_main_last_word", main_mem[1023], 32'h3FF);

    // T2: main window bounds
    do_read(32'h3FF, d, m, lat, sel, off, wsel, fa, fln);
    chk("t2_3ff_data", d, 32'h3FF);
    chk("t2_3ff_miss", 32'(m), 0);
    chk("t2_3ff_lat", lat, 3);
    chk("t2_3ff_sel", 32'(sel), 0);
    chk("t2_3ff_off", 32'(off), 32'h3FF);
    do_read(32'h0, d, m, lat, sel, off, wsel, fa, fln);
    chk("t2_0_data", d, 32'h0);
    chk("t2_0_lat", lat, 3);
    do_read(32'h400, d, m, lat, sel, off, wsel, fa, fln);
    chk("t2_400_fl_addr", fa, 32'h400);
    chk("t2_400_fl_len", fln, 32'd256);
    chk("t2_400_miss", 32'(m), 1);
    chk("t2_400_data", d, 32'hC0DE_0400);

    // T3: miss then hit in the same sub block
    reset_init();
    do_read(32'h1234, d, m, lat, sel, off, wsel, fa, fln);
    chk("t3_1234_fl_addr", fa, 32'h1200);
    chk("t3_1234_wsel", 32'(wsel), 1);
    chk("t3_1234_miss", 32'(m), 1);
    chk("t3_1234_data", d, 32'hC0DE_1234);
    do_read(32'h12FF, d, m, lat, sel, off, wsel, fa, fln);
    chk("t3_12ff_miss", 32'(m), 0);
    chk("t3_12ff_lat", lat, 3);
    chk("t3_12ff_sel", 32'(sel), 1);
    chk("t3_12ff_off", 32'(off), 32'hFF);
    chk("t3_12ff_data", d, 32'hC0DE_12FF);

    // T4: second-chance replacement
    reset_init();
    addrs[0] = 32'h1000; addrs[1] = 32'h2000; addrs[2] = 32'h3000; addrs[3] = 32'h4000;
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], d, m, lat, sel, off, wsel, fa, fln);
      chk("t4_fill_wsel", 32'(wsel), i + 1);
    end
    do_read(32'h2000, d, m, lat, sel, off, wsel, fa, fln);
    chk("t4_2000_hit", 32'(m), 0);
    do_read(32'h5000, d, m, lat, sel, off, wsel, fa, fln);
    chk("t4_5000_miss", 32'(m), 1);
    chk("t4_5000_victim", 32'(wsel), 1);
    do_read(32'h2000, d, m, lat, sel, off, wsel, fa, fln);
    chk("t4_2000_still_hit", 32'(m), 0);
    chk("t4_2000_sel", 32'(sel), 2);
    do_read(32'h1000, d, m, lat, sel, off, wsel, fa, fln);
    chk("t4_1000_evicted", 32'(m), 1);
    chk("t4_1000_victim", 32'(wsel), 3);

    // T5: reset in the middle of a fill
    reset_init();
    @(negedge clk);
    re = 1'b1; raddr = 32'h1234;
    @(negedge clk);
    re = 1'b0;
    cnt = 0;
    for (k = 0; k < 2000 && cnt < 100; k++) begin
      #2 if (mem_we) cnt++;
      @(negedge clk);
    end
    chk("t5_words_before_reset", cnt, 100);
    grst_n = 1'b0;
    #1;
    chk("t5_fl_req_drop", 32'(fl_req), 0);
    chk("t5_we_drop", 32'(mem_we), 0);
    chk("t5_init_done_drop", 32'(init_done), 0);
    repeat (2) @(negedge clk);
    grst_n = 1'b1;
    wait_init(nwe);
    chk("t5_reinit_writes", nwe, 1024);
    do_read(32'h1234, d, m, lat, sel, off, wsel, fa, fln);
    chk("t5_1234_miss_again", 32'(m), 1);
    chk("t5_1234_data", d, 32'hC0DE_1234);

    // T6: re held high across a gapped fill
    reset_init();
    gap_en = 1'b1;
    n_acc = 0; n_rv = 0; nwe = 0;
    @(negedge clk);
    re = 1'b1; raddr = 32'h1234;
    for (k = 0; k < 3000; k++) begin
      #2;
      if (re && rready) n_acc++;
      if (mem_we) nwe++;
      if (rvalid) begin n_rv++; break; end
      @(negedge clk);
    end
    @(negedge clk);
    re = 1'b0;
    repeat (4) begin
      #2 if (rvalid) n_rv++;
      @(negedge clk);
    end
    gap_en = 1'b0;
    chk("t6_accepts", n_acc, 1);
    chk("t6_rvalids", n_rv, 1);
    chk("t6_fill_words", nwe, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
